// File: rtl/tmr_alu.sv
// tmr_alu: ALU with triple-modular-redundant operand coding.
//
// Each operand arrives as three concatenated copies {copy2, copy1, copy0}.
// The copies are majority-voted bit by bit, the voted operands are
// registered together with the op code and the vote flags (stage 1), and
// the ALU result is registered in the output stage (stage 2).
//
// Handshake: a transfer happens on a rising clock edge when valid and ready
// are both high. The whole pipeline moves on the shared enable
// en = !out_valid || out_ready, which is also in_ready; with en low every
// stage holds. The producer keeps its data stable while valid is high and
// ready is low.
//
// Build option: define TMR_ALU_ERRCNT_EN to add the saturating error
// counter behind err_count. Without it err_count is tied to zero and no
// counter register exists.

module tmr_alu #(
   parameter int DATA_W   = 4,
   parameter int ERRCNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3*DATA_W-1:0]   a_coded,
   input  logic [3*DATA_W-1:0]   b_coded,
   input  logic [2:0]            op,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     result_uncoded,
   output logic [3*DATA_W-1:0]   result_coded,
   output logic                  carry,
   output logic                  corrected,
   output logic                  fatal,
   output logic [ERRCNT_W-1:0]   err_count
);

   // Operation encodings
   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_PASS = 3'b101;
   localparam logic [2:0] OP_ACC  = 3'b110;
   localparam logic [2:0] OP_CLR  = 3'b111;

   // ------------------------------------------------------------------
   // Input decode: copy split, majority vote and disagreement flags
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] a_c0, a_c1, a_c2;
   logic [DATA_W-1:0] b_c0, b_c1, b_c2;
   logic [DATA_W-1:0] a_vote, b_vote;
   logic              a_any_diff, b_any_diff;
   logic              a_all_diff, b_all_diff;
   logic              in_fatal, in_corr;

   assign a_c0 = a_coded[DATA_W-1:0];
   assign a_c1 = a_coded[2*DATA_W-1:DATA_W];
   assign a_c2 = a_coded[3*DATA_W-1:2*DATA_W];
   assign b_c0 = b_coded[DATA_W-1:0];
   assign b_c1 = b_coded[2*DATA_W-1:DATA_W];
   assign b_c2 = b_coded[3*DATA_W-1:2*DATA_W];

   // Per-bit majority of the three copies
   always_comb begin
      a_vote = (a_c0 & a_c1) | (a_c1 & a_c2) | (a_c0 & a_c2);
      b_vote = (b_c0 & b_c1) | (b_c1 & b_c2) | (b_c0 & b_c2);
   end

   // Disagreement detection; a word with three pairwise-different copies
   // cannot be trusted even though the per-bit vote still yields a value
   always_comb begin
      a_any_diff = (a_c0 != a_vote) || (a_c1 != a_vote) || (a_c2 != a_vote);
      b_any_diff = (b_c0 != b_vote) || (b_c1 != b_vote) || (b_c2 != b_vote);
      a_all_diff = (a_c0 != a_c1) && (a_c1 != a_c2) && (a_c0 != a_c2);
      b_all_diff = (b_c0 != b_c1) && (b_c1 != b_c2) && (b_c0 != b_c2);
      in_fatal   = a_all_diff || b_all_diff;
      in_corr    = (a_any_diff || b_any_diff) && !in_fatal;
   end

   // ------------------------------------------------------------------
   // Pipeline control
   // ------------------------------------------------------------------
   logic en;
   logic advance;

   logic              s1_valid;
   logic [DATA_W-1:0] s1_a;
   logic [DATA_W-1:0] s1_b;
   logic [2:0]        s1_op;
   logic              s1_corr;
   logic              s1_fatal;

   logic [DATA_W-1:0] acc;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;
   // A stage-1 entry moves into the output register on this edge
   assign advance  = en && s1_valid;

   // Stage 1: voted operands, op code and vote flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= OP_ADD;
         s1_corr  <= 1'b0;
         s1_fatal <= 1'b0;
      end else if (en) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_a     <= a_vote;
            s1_b     <= b_vote;
            s1_op    <= op;
            s1_corr  <= in_corr;
            s1_fatal <= in_fatal;
         end
      end
   end

   // ------------------------------------------------------------------
   // ALU on the stage-1 entry. The accumulator is read here and written
   // on the same edge the entry advances, so a following ACC in stage 1
   // always sees the updated value.
   // ------------------------------------------------------------------
   logic [DATA_W:0]   sum_ab;
   logic [DATA_W:0]   dif_ab;
   logic [DATA_W:0]   acc_sum;
   logic [DATA_W-1:0] alu_res;
   logic              alu_carry;
   logic [DATA_W-1:0] acc_next;

   // Widened arithmetic so the top bit is the carry or borrow
   always_comb begin
      sum_ab  = {1'b0, s1_a} + {1'b0, s1_b};
      dif_ab  = {1'b0, s1_a} - {1'b0, s1_b};
      acc_sum = {1'b0, acc}  + {1'b0, s1_a};
   end

   // Operation select, carry and accumulator next value
   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      acc_next  = acc;
      case (s1_op)
         OP_ADD: begin
            alu_res   = sum_ab[DATA_W-1:0];
            alu_carry = sum_ab[DATA_W];
         end
         OP_SUB: begin
            alu_res   = dif_ab[DATA_W-1:0];
            alu_carry = dif_ab[DATA_W];
         end
         OP_AND:  alu_res = s1_a & s1_b;
         OP_OR:   alu_res = s1_a | s1_b;
         OP_XOR:  alu_res = s1_a ^ s1_b;
         OP_PASS: alu_res = s1_a;
         OP_ACC: begin
            alu_res   = acc_sum[DATA_W-1:0];
            alu_carry = acc_sum[DATA_W];
            acc_next  = acc_sum[DATA_W-1:0];
         end
         OP_CLR: begin
            alu_res  = '0;
            acc_next = '0;
         end
         default: begin
            alu_res = '0;
         end
      endcase
   end

   // Accumulator register, touched only when an entry advances
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc <= '0;
      end else if (advance) begin
         acc <= acc_next;
      end
   end

   // Stage 2: output register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid      <= 1'b0;
         result_uncoded <= '0;
         carry          <= 1'b0;
         corrected      <= 1'b0;
         fatal          <= 1'b0;
      end else if (en) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            result_uncoded <= alu_res;
            carry          <= alu_carry;
            corrected      <= s1_corr;
            fatal          <= s1_fatal;
         end
      end
   end

   // The coded result is the voted result replicated; it needs no register
   assign result_coded = {result_uncoded, result_uncoded, result_uncoded};

   // ------------------------------------------------------------------
   // Error counter
   // ------------------------------------------------------------------
`ifdef TMR_ALU_ERRCNT_EN
   logic [ERRCNT_W-1:0] err_q;
   localparam logic [ERRCNT_W-1:0] ERR_ONE = {{(ERRCNT_W-1){1'b0}}, 1'b1};

   // Saturating count of advancing entries flagged corrected or fatal
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= '0;
      end else if (advance && (s1_corr || s1_fatal) && (err_q != '1)) begin
         err_q <= err_q + ERR_ONE;
      end
   end

   assign err_count = err_q;
`else
   assign err_count = '0;
`endif

endmodule

// File: doc/tmr_alu.md
TMR_ALU -- requirements
Module: tmr_alu

Interface
REQ-001 Parameter DATA_W, default 4, width of one decoded operand copy.
REQ-002 Parameter ERRCNT_W, default 8, width of the error counter.
REQ-003 The module SHALL have ports:
  clk  input  1  rising-edge clock
  rst  input  1  asynchronous, active-low reset
  in_valid  input  1  operand set presented
  in_ready  output  1  operand set accepted when in_valid && in_ready
  a_coded  input  3*DATA_W  operand A, three concatenated copies (copy2,copy1,copy0)
  b_coded  input  3*DATA_W  operand B, same coding
  op  input  3  operation select
  out_valid  output  1  result held
  out_ready  input  1  result consumed when out_valid && out_ready
  result_uncoded  output  DATA_W  voted result
  result_coded  output  3*DATA_W  result replicated three times
  carry  output  1  carry/borrow of ADD, SUB and ACC
  corrected  output  1  at least one copy of A or B disagreed and was outvoted
  fatal  output  1  all three copies of A or of B pairwise differ
  err_count  output  ERRCNT_W  saturating count of corrected-or-fatal transactions

Function
REQ-004 Per-bit majority vote SHALL decode each operand: bit i = maj(copy0[i], copy1[i], copy2[i]).
REQ-005 corrected SHALL be set when any copy differs from the voted word and fatal is clear.
REQ-006 fatal SHALL be set when copy0!=copy1, copy1!=copy2 and copy0!=copy2 for A or for B; fatal and corrected SHALL never both be 1.
REQ-007 op codes SHALL be: 000 ADD A+B; 001 SUB A-B; 010 AND; 011 OR; 100 XOR; 101 PASS A; 110 ACC; 111 CLR.
REQ-008 ADD, SUB and ACC results SHALL wrap modulo 2^DATA_W. carry SHALL be the carry-out bit for ADD and ACC, the borrow for SUB, and 0 for all other ops.
REQ-009 ACC SHALL update the internal accumulator to acc+A and return the new value. CLR SHALL set acc to 0 and return 0. No other op SHALL change acc.
REQ-010 The pipeline SHALL have two register stages: stage 1 holds the voted operands, op and flags; stage 2 is the output register. out_valid SHALL rise exactly 2 cycles after acceptance when there is no stall.
REQ-011 The pipeline enable SHALL be en = !out_valid || out_ready, and in_ready SHALL equal en. When en=0 all stages SHALL hold their contents.
REQ-012 Back-to-back acceptance SHALL sustain 1 result per cycle while out_ready=1.
REQ-013 ACC ops issued back-to-back SHALL each see the accumulator value updated by the preceding ACC or CLR, with no hazard.
REQ-014 result_coded SHALL equal {result_uncoded, result_uncoded, result_uncoded}.
REQ-015 The acc update and err_count increment SHALL occur only when a stage-1 entry advances into stage 2.

Reset
REQ-016 While rst=0 the module SHALL clear all valid bits, out_valid, result_uncoded, result_coded, carry, corrected, fatal, acc and err_count to 0, asynchronously.
REQ-017 Reset asserted mid-operation SHALL discard in-flight entries. The first cycle after release SHALL present in_ready=1.

Configuration
REQ-018 With macro TMR_ALU_ERRCNT_EN defined, err_count SHALL increment on each result with corrected or fatal set, saturating at 2^ERRCNT_W-1.
REQ-019 Without TMR_ALU_ERRCNT_EN, err_count SHALL be constant 0 and no counter register SHALL be synthesised.

Verification (DATA_W=4)
REQ-020 A=0x111, B=0x222, op=ADD, out_ready=1 -> result_uncoded=3 two cycles later, result_coded=0x333, corrected=0, fatal=0.
REQ-021 A=0x151 (one bad copy), B=0x111, op=ADD -> result_uncoded=2, corrected=1, err_count increments by 1 (macro on).
REQ-022 A=0x321, op=PASS -> fatal=1, corrected=0.
REQ-023 CLR, then ACC A=0xFFF, then ACC A=0x222 back-to-back -> results 0, F (carry 0), then 1 (carry 1).
REQ-024 out_ready=0 for 3 cycles with 3 inputs offered -> in_ready falls once out_valid=1; no result lost or duplicated; order preserved after release.
REQ-025 rst=0 pulse while 2 entries are in flight -> out_valid=0 and acc=0 immediately; the next accepted ADD 0x111+0x111 returns 2.
